// File: rtl/shift_issue_stage_pkg.sv
// Shared request-kind and shifter-operation encodings for the shift issue stage.
package shift_issue_stage_pkg;

    localparam int unsigned DEF_OPERAND_WIDTH  = 16;
    localparam int unsigned DEF_SHAMT_WIDTH    = 4;
    localparam int unsigned DEF_NUM_OPERATIONS = 2;

    typedef enum logic [2:0] {
        KIND_ROL = 3'b000,
        KIND_SLL = 3'b001,
        KIND_SRA = 3'b010,
        KIND_SRL = 3'b011,
        KIND_ROR = 3'b100
    } req_kind_e;

    typedef enum logic [1:0] {
        OPER_ROL = 2'b00,
        OPER_SLL = 2'b01,
        OPER_SRA = 2'b10,
        OPER_SRL = 2'b11
    } sh_oper_e;

endpackage

// File: rtl/shift_issue_stage_skid_buf.sv
// Two-entry FIFO skid buffer with head/tail pointers, occupancy count and synchronous flush.
module skid_buf #(
    parameter int unsigned WIDTH = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] mem_q [2];
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    // Ready depends only on stored occupancy, so a same-cycle drain never opens it.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[head_q];

    always_comb begin
        push    = in_valid && in_ready && !flush;
        pop     = out_valid && out_ready && !flush;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) tail_d = ~tail_q;
            if (pop)  head_d = ~head_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) mem_q[tail_q] <= in_data;
        end
    end

endmodule

// File: rtl/shift_issue_stage.sv
// Issue stage ahead of the barrel shifter: canonicalises shift requests and buffers
// them in a two-entry skid buffer; illegal kinds are consumed and flagged.
module shift_issue_stage
    import shift_issue_stage_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH  = DEF_OPERAND_WIDTH,
    parameter int unsigned SHAMT_WIDTH    = DEF_SHAMT_WIDTH,
    parameter int unsigned NUM_OPERATIONS = DEF_NUM_OPERATIONS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [OPERAND_WIDTH-1:0]  req_data,
    input  logic [SHAMT_WIDTH-1:0]    req_amt,
    input  logic [2:0]                req_kind,
    output logic                      sh_valid,
    input  logic                      sh_ready,
    output logic [OPERAND_WIDTH-1:0]  sh_in,
    output logic [SHAMT_WIDTH-1:0]    sh_amt,
    output logic [NUM_OPERATIONS-1:0] sh_oper,
    output logic                      err_kind
);

    localparam int unsigned ENTRY_W = OPERAND_WIDTH + SHAMT_WIDTH + NUM_OPERATIONS;

    logic                      kind_legal;
    logic [SHAMT_WIDTH-1:0]    canon_amt;
    logic [NUM_OPERATIONS-1:0] canon_oper;
    logic                      enq_valid;
    logic [ENTRY_W-1:0]        head_entry;
    logic                      err_kind_q, err_kind_d;

    // ROR by n equals ROL by (2^SHAMT_WIDTH - n), so the shifter never sees ROR.
    always_comb begin
        kind_legal = 1'b1;
        canon_amt  = req_amt;
        canon_oper = NUM_OPERATIONS'(OPER_ROL);
        case (req_kind)
            KIND_ROL: canon_oper = NUM_OPERATIONS'(OPER_ROL);
            KIND_SLL: canon_oper = NUM_OPERATIONS'(OPER_SLL);
            KIND_SRA: canon_oper = NUM_OPERATIONS'(OPER_SRA);
            KIND_SRL: canon_oper = NUM_OPERATIONS'(OPER_SRL);
            KIND_ROR: begin
                canon_oper = NUM_OPERATIONS'(OPER_ROL);
                canon_amt  = '0 - req_amt;
            end
            default:  kind_legal = 1'b0;
        endcase
    end

    assign enq_valid  = req_valid && kind_legal;
    assign err_kind_d = req_valid && req_ready && !kind_legal && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_kind_q <= 1'b0;
        else     err_kind_q <= err_kind_d;
    end

    skid_buf #(
        .WIDTH(ENTRY_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (enq_valid),
        .in_ready  (req_ready),
        .in_data   ({req_data, canon_amt, canon_oper}),
        .out_valid (sh_valid),
        .out_ready (sh_ready),
        .out_data  (head_entry)
    );

    assign {sh_in, sh_amt, sh_oper} = head_entry;
    assign err_kind                 = err_kind_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_shift_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_data = '0;
    logic [3:0]  req_amt = '0;
    logic [2:0]  req_kind = '0;
    logic        sh_valid;
    logic        sh_ready = 1'b0;
    logic [15:0] sh_in;
    logic [3:0]  sh_amt;
    logic [1:0]  sh_oper;
    logic        err_kind;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [21:0] mq[$];
    bit          err_m = 1'b0;

    always #5 clk = ~clk;

    shift_issue_stage #(
        .OPERAND_WIDTH (16),
        .SHAMT_WIDTH   (4),
        .NUM_OPERATIONS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .req_amt  (req_amt),
        .req_kind (req_kind),
        .sh_valid (sh_valid),
        .sh_ready (sh_ready),
        .sh_in    (sh_in),
        .sh_amt   (sh_amt),
        .sh_oper  (sh_oper),
        .err_kind (err_kind)
    );

    // Expected shifter request {in, amt, oper} for a raw request.
    function automatic logic [21:0] canon(input logic [15:0] d, input logic [3:0] a,
                                          input logic [2:0] k, output bit legal);
        logic [3:0] ror_amt;
        ror_amt = 4'((16 - int'(a)) % 16);
        legal = 1'b1;
        case (k)
            3'd0:    return {d, a, 2'b00};
            3'd1:    return {d, a, 2'b01};
            3'd2:    return {d, a, 2'b10};
            3'd3:    return {d, a, 2'b11};
            3'd4:    return {d, ror_amt, 2'b00};
            default: begin legal = 1'b0; return '0; end
        endcase
    endfunction

    // Advance the model by one edge using the inputs currently driven, then step the DUT.
    task automatic tick();
        bit          legal, ready_m, pop, acc;
        logic [21:0] e;
        e       = canon(req_data, req_amt, req_kind, legal);
        ready_m = (mq.size() < 2);
        if (flush) begin
            mq.delete();
            err_m = 1'b0;
        end else begin
            pop = (mq.size() > 0) && sh_ready;
            acc = req_valid && ready_m;
            if (pop) void'(mq.pop_front());
            if (acc && legal) mq.push_back(e);
            err_m = acc && !legal;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit v, input logic [2:0] k, input logic [15:0] d, input logic [3:0] a);
        req_valid = v;
        req_kind  = k;
        req_data  = d;
        req_amt   = a;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        err_m = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({sh_valid, sh_in, sh_amt, sh_oper, err_kind} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b in=%h amt=%h oper=%b err=%b, want all 0",
                     sh_valid, sh_in, sh_amt, sh_oper, err_kind);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_ror();
        logic [31:0] dbl;
        sh_ready = 1'b0;
        set_req(1'b1, 3'b100, 16'h8001, 4'd1);
        tick();
        set_req(1'b0, 3'b000, 16'h0000, 4'd0);
        n_checks++;
        if ({sh_valid, sh_oper, sh_amt, sh_in} !== {1'b1, 2'b00, 4'd15, 16'h8001}) begin
            n_fail++;
            $display("FAIL ror_canon: got valid=%b oper=%b amt=%0d in=%h want 1 00 15 8001",
                     sh_valid, sh_oper, sh_amt, sh_in);
        end
        dbl = {sh_in, sh_in} << sh_amt;
        n_checks++;
        if (dbl[31:16] !== 16'hC000) begin
            n_fail++;
            $display("FAIL ror_result: got %h want c000", dbl[31:16]);
        end
        sh_ready = 1'b1;
        tick();
        sh_ready = 1'b0;
        n_checks++;
        if (sh_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ror_drain: sh_valid got %b want 0", sh_valid);
        end
    endtask

    task automatic test_backpressure();
        sh_ready = 1'b0;
        set_req(1'b1, 3'b001, 16'h1234, 4'd3);
        tick();
        set_req(1'b1, 3'b010, 16'hF00F, 4'd2);
        tick();
        set_req(1'b0, 3'b000, 16'h0000, 4'd0);
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full_ready: got %b want 0", req_ready);
        end
        tick();
        n_checks++;
        if ({sh_valid, sh_in, sh_amt, sh_oper} !== {1'b1, 16'h1234, 4'd3, 2'b01}) begin
            n_fail++;
            $display("FAIL bp_hold_first: got %b %h %0d %b want 1 1234 3 01",
                     sh_valid, sh_in, sh_amt, sh_oper);
        end
        sh_ready = 1'b1;
        tick();
        n_checks++;
        if ({sh_valid, sh_in, sh_amt, sh_oper} !== {1'b1, 16'hF00F, 4'd2, 2'b10}) begin
            n_fail++;
            $display("FAIL bp_second: got %b %h %0d %b want 1 f00f 2 10",
                     sh_valid, sh_in, sh_amt, sh_oper);
        end
        tick();
        sh_ready = 1'b0;
        n_checks++;
        if (sh_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: sh_valid got %b want 0", sh_valid);
        end
    endtask

    task automatic test_full_drain();
        sh_ready = 1'b0;
        set_req(1'b1, 3'b000, 16'hAAAA, 4'd5);
        tick();
        set_req(1'b1, 3'b011, 16'h5555, 4'd7);
        tick();
        set_req(1'b1, 3'b001, 16'hDEAD, 4'd1);
        sh_ready = 1'b1;
        tick();
        set_req(1'b0, 3'b000, 16'h0000, 4'd0);
        n_checks++;
        if ({req_ready, sh_valid, sh_in, sh_amt, sh_oper} !== {1'b1, 1'b1, 16'h5555, 4'd7, 2'b11}) begin
            n_fail++;
            $display("FAIL full_drain_one: got ready=%b valid=%b %h %0d %b want 1 1 5555 7 11",
                     req_ready, sh_valid, sh_in, sh_amt, sh_oper);
        end
        tick();
        sh_ready = 1'b0;
        n_checks++;
        if (sh_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_dup: sh_valid got %b want 0", sh_valid);
        end
    endtask

    task automatic test_illegal();
        sh_ready = 1'b0;
        set_req(1'b1, 3'b001, 16'h0F0F, 4'd4);
        tick();
        set_req(1'b1, 3'b110, 16'hBEEF, 4'd9);
        tick();
        set_req(1'b0, 3'b000, 16'h0000, 4'd0);
        n_checks++;
        if ({err_kind, req_ready, sh_valid, sh_in} !== {1'b1, 1'b1, 1'b1, 16'h0F0F}) begin
            n_fail++;
            $display("FAIL illegal_pulse: got err=%b ready=%b valid=%b in=%h want 1 1 1 0f0f",
                     err_kind, req_ready, sh_valid, sh_in);
        end
        tick();
        n_checks++;
        if (err_kind !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_one_cycle: err_kind got %b want 0", err_kind);
        end
        sh_ready = 1'b1;
        tick();
        sh_ready = 1'b0;
        n_checks++;
        if (sh_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_not_enqueued: sh_valid got %b want 0", sh_valid);
        end
    endtask

    task automatic test_flush();
        sh_ready = 1'b0;
        set_req(1'b1, 3'b010, 16'h1111, 4'd1);
        tick();
        set_req(1'b1, 3'b011, 16'h2222, 4'd2);
        tick();
        set_req(1'b1, 3'b110, 16'h3333, 4'd3);
        flush = 1'b1;
        sh_ready = 1'b1;
        tick();
        flush = 1'b0;
        sh_ready = 1'b0;
        set_req(1'b0, 3'b000, 16'h0000, 4'd0);
        n_checks++;
        if ({sh_valid, req_ready, err_kind} !== 3'b010) begin
            n_fail++;
            $display("FAIL flush_state: got valid=%b ready=%b err=%b want 0 1 0",
                     sh_valid, req_ready, err_kind);
        end
        tick();
        n_checks++;
        if (sh_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_ghost: sh_valid got %b want 0", sh_valid);
        end
    endtask

    task automatic test_async_reset();
        sh_ready = 1'b0;
        set_req(1'b1, 3'b000, 16'h7777, 4'd6);
        tick();
        set_req(1'b1, 3'b001, 16'h8888, 4'd8);
        tick();
        #3;
        rst = 1'b1;
        mq.delete();
        err_m = 1'b0;
        #1;
        n_checks++;
        if ({sh_valid, sh_in, sh_amt, sh_oper, err_kind} !== 24'd0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b in=%h amt=%h oper=%b err=%b want all 0",
                     sh_valid, sh_in, sh_amt, sh_oper, err_kind);
        end
        set_req(1'b0, 3'b000, 16'h0000, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_req(1'b1, 3'b100, 16'h1234, 4'd0);
        tick();
        set_req(1'b0, 3'b000, 16'h0000, 4'd0);
        n_checks++;
        if ({sh_valid, sh_oper, sh_amt, sh_in} !== {1'b1, 2'b00, 4'd0, 16'h1234}) begin
            n_fail++;
            $display("FAIL ror_zero: got valid=%b oper=%b amt=%0d in=%h want 1 00 0 1234",
                     sh_valid, sh_oper, sh_amt, sh_in);
        end
        sh_ready = 1'b1;
        tick();
        sh_ready = 1'b0;
    endtask

    task automatic test_random();
        int unsigned bad = 0;
        for (int i = 0; i < 500; i++) begin
            set_req($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                    16'($urandom), 4'($urandom));
            sh_ready = $urandom_range(0, 2) != 0;
            flush    = $urandom_range(0, 24) == 0;
            tick();
            n_checks++;
            if (req_ready !== (mq.size() < 2) || sh_valid !== (mq.size() > 0) ||
                err_kind !== err_m ||
                (mq.size() > 0 && {sh_in, sh_amt, sh_oper} !== mq[0])) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: got ready=%b valid=%b err=%b head=%h want ready=%b valid=%b err=%b head=%h",
                             i, req_ready, sh_valid, err_kind, {sh_in, sh_amt, sh_oper},
                             mq.size() < 2, mq.size() > 0, err_m,
                             (mq.size() > 0) ? mq[0] : 22'h0);
            end
        end
        flush = 1'b0;
        set_req(1'b0, 3'b000, 16'h0000, 4'd0);
        sh_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ror();
        test_backpressure();
        test_full_drain();
        test_illegal();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
